// File: rtl/arb_pkg.sv
// Shared types for the memory-bus arbiter: FSM states, index-width helper and
// the per-channel request record latched toward the downstream port.
package arb_pkg;

    typedef logic [63:0] u64_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int MAX_AW = 64;
    localparam int MAX_DW = 64;
    localparam int MAX_SW = MAX_DW / 8;

    // Channel index width; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sized for the widest supported bus; narrower AW/DW use the low bits.
    typedef struct packed {
        u64_t              addr;
        logic [2:0]        size;
        logic [MAX_SW-1:0] strobe;
        u64_t              wdata;
    } arb_req_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Upstream request channels plus the single downstream memory port.
// slave = arbiter side, master = requesters/memory side.
interface bus_arbiter_if #(
    parameter int NCH = 2,
    parameter int AW  = 64,
    parameter int DW  = 64
);
    localparam int SW = DW / 8;

    logic [NCH-1:0]    s_valid;
    logic [NCH*AW-1:0] s_addr;
    logic [NCH*3-1:0]  s_size;
    logic [NCH*SW-1:0] s_strobe;
    logic [NCH*DW-1:0] s_wdata;
    logic [NCH-1:0]    s_data_ok;
    logic [DW-1:0]     s_rdata;

    logic              m_valid;
    logic [AW-1:0]     m_addr;
    logic [2:0]        m_size;
    logic [SW-1:0]     m_strobe;
    logic [DW-1:0]     m_wdata;
    logic              m_data_ok;
    logic [DW-1:0]     m_rdata;

    modport slave (
        input  s_valid, s_addr, s_size, s_strobe, s_wdata,
        output s_data_ok, s_rdata,
        output m_valid, m_addr, m_size, m_strobe, m_wdata,
        input  m_data_ok, m_rdata
    );

    modport master (
        output s_valid, s_addr, s_size, s_strobe, s_wdata,
        input  s_data_ok, s_rdata,
        input  m_valid, m_addr, m_size, m_strobe, m_wdata,
        output m_data_ok, m_rdata
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational winner selection: rotate the request vector to start at ptr
// (round-robin) or at 0 (fixed priority) and take the first set bit.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int MODE = 0
) (
    input  logic [NCH-1:0]              req,
    input  logic [idx_width(NCH)-1:0]   ptr,
    output logic [idx_width(NCH)-1:0]   win,
    output logic                        any_valid
);

    localparam int IW = idx_width(NCH);
    localparam logic [IW:0] NCH_W = (IW+1)'(NCH);

    logic [IW:0] base;
    logic [IW:0] idx;

    // Walk offsets from the far end so the nearest requester overwrites last;
    // the wrap is at NCH, not at a power of two.
    always_comb begin
        any_valid = |req;
        win       = '0;
        base      = (MODE == 1) ? '0 : {1'b0, ptr};
        idx       = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = base + (IW+1)'(i);
            if (idx >= NCH_W) begin
                idx = idx - NCH_W;
            end
            if (req[idx[IW-1:0]]) begin
                win = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// N-channel memory-bus arbiter: picks one requester, registers its request
// onto the downstream port and routes the completion back, with optional timeout.
module bus_arbiter
    import arb_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int MODE    = 0,
    parameter int TIMEOUT = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    bus_arbiter_if.slave              bus,
    output logic [idx_width(NCH)-1:0] grant_id,
    output logic                      busy,
    output logic                      err_timeout
);

    // state | meaning
    // IDLE  | no transaction; winner chosen and latched when any s_valid is high
    // BUSY  | downstream request held until m_data_ok or timeout

    localparam int IW = idx_width(NCH);
    localparam int SW = DW / 8;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    arb_req_t        req_q, req_d;

    logic [IW-1:0]   win;
    logic            any_valid;
    logic            tmo_hit;
    logic [IW-1:0]   ptr_after;

    rr_pick #(
        .NCH  (NCH),
        .MODE (MODE)
    ) u_pick (
        .req       (bus.s_valid),
        .ptr       (rr_ptr_q),
        .win       (win),
        .any_valid (any_valid)
    );

    assign tmo_hit   = (TIMEOUT > 0) && (tmo_cnt_q == TW'(TIMEOUT - 1));
    assign ptr_after = (grant_q == IW'(NCH - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        tmo_cnt_d     = tmo_cnt_q;
        req_d         = req_q;
        bus.s_data_ok = '0;
        bus.s_rdata   = '0;
        err_timeout   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d   = win;
                    tmo_cnt_d = '0;
                    state_d   = BUSY;
                    for (int c = 0; c < NCH; c++) begin
                        if (win == IW'(c)) begin
                            req_d.addr   = u64_t'(bus.s_addr[c*AW +: AW]);
                            req_d.size   = bus.s_size[c*3 +: 3];
                            req_d.strobe = MAX_SW'(bus.s_strobe[c*SW +: SW]);
                            req_d.wdata  = u64_t'(bus.s_wdata[c*DW +: DW]);
                        end
                    end
                end
            end
            BUSY: begin
                if (bus.m_data_ok) begin
                    bus.s_data_ok[grant_q] = 1'b1;
                    bus.s_rdata            = bus.m_rdata;
                    state_d                = IDLE;
                    if (MODE == 0) rr_ptr_d = ptr_after;
                end else if (tmo_hit) begin
                    // Forced completion advances the pointer like a normal one
                    // so a stuck channel cannot monopolise the port.
                    bus.s_data_ok[grant_q] = 1'b1;
                    err_timeout            = 1'b1;
                    state_d                = IDLE;
                    if (MODE == 0) rr_ptr_d = ptr_after;
                end else if (TIMEOUT > 0) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            tmo_cnt_q <= '0;
            req_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            tmo_cnt_q <= tmo_cnt_d;
            req_q     <= req_d;
        end
    end

    assign bus.m_valid  = (state_q == BUSY);
    assign bus.m_addr   = req_q.addr[AW-1:0];
    assign bus.m_size   = req_q.size;
    assign bus.m_strobe = req_q.strobe[SW-1:0];
    assign bus.m_wdata  = req_q.wdata[DW-1:0];
    assign grant_id     = grant_q;
    assign busy         = (state_q == BUSY);

endmodule

// File: tb/tb_bus_arbiter.sv
// Two 3-channel arbiters (round-robin and fixed priority, TIMEOUT=8) driven in
// lockstep; a scoreboard queue of expected requests/completions feeds a monitor.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NCH(3), .AW(64), .DW(64)) if_a ();
    bus_arbiter_if #(.NCH(3), .AW(64), .DW(64)) if_b ();

    logic [1:0] gid_a, gid_b;
    logic       busy_a, busy_b, err_a, err_b;

    bus_arbiter #(.NCH(3), .AW(64), .DW(64), .MODE(0), .TIMEOUT(8)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave),
        .grant_id(gid_a), .busy(busy_a), .err_timeout(err_a)
    );

    bus_arbiter #(.NCH(3), .AW(64), .DW(64), .MODE(1), .TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave),
        .grant_id(gid_b), .busy(busy_b), .err_timeout(err_b)
    );

    // Per-DUT requester state (index 0 = round-robin DUT, 1 = fixed priority)
    logic [2:0]  vld      [2];
    logic [63:0] ch_addr  [2][3];
    logic [2:0]  ch_size  [2][3];
    logic [7:0]  ch_strb  [2][3];
    logic [63:0] ch_wdata [2][3];
    logic        m_dok;
    logic [63:0] m_rd;

    always_comb begin
        if_a.s_valid   = vld[0];
        if_a.s_addr    = {ch_addr[0][2], ch_addr[0][1], ch_addr[0][0]};
        if_a.s_size    = {ch_size[0][2], ch_size[0][1], ch_size[0][0]};
        if_a.s_strobe  = {ch_strb[0][2], ch_strb[0][1], ch_strb[0][0]};
        if_a.s_wdata   = {ch_wdata[0][2], ch_wdata[0][1], ch_wdata[0][0]};
        if_a.m_data_ok = m_dok;
        if_a.m_rdata   = m_rd;
        if_b.s_valid   = vld[1];
        if_b.s_addr    = {ch_addr[1][2], ch_addr[1][1], ch_addr[1][0]};
        if_b.s_size    = {ch_size[1][2], ch_size[1][1], ch_size[1][0]};
        if_b.s_strobe  = {ch_strb[1][2], ch_strb[1][1], ch_strb[1][0]};
        if_b.s_wdata   = {ch_wdata[1][2], ch_wdata[1][1], ch_wdata[1][0]};
        if_b.m_data_ok = m_dok;
        if_b.m_rdata   = m_rd;
    end

    logic        mv    [2];
    logic        bsy   [2];
    logic        errt  [2];
    logic [1:0]  gid   [2];
    logic [2:0]  dok   [2];
    logic [63:0] rdat  [2];
    logic [63:0] maddr [2];
    logic [63:0] mwd   [2];
    logic [2:0]  msize [2];
    logic [7:0]  mstrb [2];

    always_comb begin
        mv[0] = if_a.m_valid;   mv[1] = if_b.m_valid;
        bsy[0] = busy_a;        bsy[1] = busy_b;
        errt[0] = err_a;        errt[1] = err_b;
        gid[0] = gid_a;         gid[1] = gid_b;
        dok[0] = if_a.s_data_ok; dok[1] = if_b.s_data_ok;
        rdat[0] = if_a.s_rdata; rdat[1] = if_b.s_rdata;
        maddr[0] = if_a.m_addr; maddr[1] = if_b.m_addr;
        mwd[0] = if_a.m_wdata;  mwd[1] = if_b.m_wdata;
        msize[0] = if_a.m_size; msize[1] = if_b.m_size;
        mstrb[0] = if_a.m_strobe; mstrb[1] = if_b.m_strobe;
    end

    typedef struct {
        int          dut;
        logic [1:0]  gid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } exp_req_t;

    typedef struct {
        int          dut;
        logic [2:0]  onehot;
        logic [63:0] rdata;
        logic        err;
    } exp_cpl_t;

    exp_req_t exp_req[$];
    exp_cpl_t exp_cpl[$];

    int checks = 0;
    int errors = 0;
    int ptr[2];
    bit mon_en = 1'b0;
    logic mv_prev[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requester scanning from the pointer (RR)
    // or from channel 0 (fixed priority).
    function automatic int model_pick(input int d, input logic [2:0] v);
        int start;
        start = (d == 0) ? ptr[0] : 0;
        for (int k = 0; k < 3; k++) begin
            if (v[(start + k) % 3]) return (start + k) % 3;
        end
        return -1;
    endfunction

    task automatic mon_step(input int d);
        int ri;
        int ci;
        exp_req_t r;
        exp_cpl_t c;
        ri = -1;
        ci = -1;
        foreach (exp_req[i]) if (ri < 0 && exp_req[i].dut == d) ri = i;
        foreach (exp_cpl[i]) if (ci < 0 && exp_cpl[i].dut == d) ci = i;
        if (mv[d] && !mv_prev[d]) begin
            if (ri < 0) begin
                checks++;
                errors++;
                $display("FAIL req_unexpected dut%0d: got m_valid=1 want 0", d);
            end else begin
                r = exp_req[ri];
                exp_req.delete(ri);
                chk($sformatf("req_gid%0d", d), 64'(gid[d]), 64'(r.gid));
                chk($sformatf("req_addr%0d", d), maddr[d], r.addr);
                chk($sformatf("req_wdata%0d", d), mwd[d], r.wdata);
                chk($sformatf("req_size_strb%0d", d), 64'({msize[d], mstrb[d]}), 64'({r.size, r.strb}));
            end
        end
        if (dok[d] != 3'b000) begin
            if (ci < 0) begin
                checks++;
                errors++;
                $display("FAIL cpl_unexpected dut%0d: got data_ok=%b want 000", d, dok[d]);
            end else begin
                c = exp_cpl[ci];
                exp_cpl.delete(ci);
                chk($sformatf("cpl_onehot%0d", d), 64'(dok[d]), 64'(c.onehot));
                chk($sformatf("cpl_rdata%0d", d), rdat[d], c.rdata);
                chk($sformatf("cpl_err%0d", d), 64'(errt[d]), 64'(c.err));
            end
        end else begin
            chk($sformatf("quiet_rdata%0d", d), rdat[d], 64'd0);
            chk($sformatf("quiet_err%0d", d), 64'(errt[d]), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) mon_step(d);
        end
        for (int d = 0; d < 2; d++) mv_prev[d] <= mv[d];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] junk();
        return {$urandom, $urandom} | 64'd1;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        mon_en = 1'b0;
        vld[0] = '0;
        vld[1] = '0;
        m_dok = 1'b0;
        m_rd = junk();
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_mvalid", 64'(mv[d]), 64'd0);
            chk("rst_busy", 64'(bsy[d]), 64'd0);
            chk("rst_gid", 64'(gid[d]), 64'd0);
            chk("rst_dok", 64'(dok[d]), 64'd0);
            chk("rst_err", 64'(errt[d]), 64'd0);
            chk("rst_maddr", maddr[d], 64'd0);
        end
        exp_req.delete();
        exp_cpl.delete();
        ptr[0] = 0;
        ptr[1] = 0;
        reset = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic set_req(input int d, input int ch, input logic [63:0] a,
                           input logic [7:0] s, input logic [63:0] w);
        ch_addr[d][ch]  = a;
        ch_size[d][ch]  = 3'd3;
        ch_strb[d][ch]  = s;
        ch_wdata[d][ch] = w;
        vld[d][ch]      = 1'b1;
    endtask

    task automatic add_reqs(input int d, input logic [2:0] bits);
        for (int ch = 0; ch < 3; ch++) begin
            if (bits[ch] && !vld[d][ch]) begin
                set_req(d, ch, {$urandom, $urandom}, 8'($urandom), {$urandom, $urandom});
                ch_size[d][ch] = 3'($urandom);
            end
        end
    endtask

    task automatic push_req(input int d, input int w);
        exp_req_t r;
        r.dut   = d;
        r.gid   = 2'(w);
        r.addr  = ch_addr[d][w];
        r.size  = ch_size[d][w];
        r.strb  = ch_strb[d][w];
        r.wdata = ch_wdata[d][w];
        exp_req.push_back(r);
    endtask

    // One transaction on both DUTs; dly > 8 means memory never answers.
    task automatic run_txn(input int dly, input logic [63:0] rd, input int exp_ga, input int exp_gb);
        int w[2];
        bit tmo;
        int done;
        exp_cpl_t c;
        tmo  = (dly > 8);
        done = tmo ? 8 : dly;
        for (int d = 0; d < 2; d++) begin
            w[d] = model_pick(d, vld[d]);
            push_req(d, w[d]);
            c.dut    = d;
            c.onehot = 3'(1 << w[d]);
            c.rdata  = tmo ? 64'd0 : rd;
            c.err    = tmo;
            exp_cpl.push_back(c);
        end
        ptr[0] = (w[0] + 1) % 3;
        tick();
        m_rd = junk();
        for (int d = 0; d < 2; d++) chk("latency_mvalid", 64'(mv[d]), 64'd1);
        if (exp_ga >= 0) chk("grant_a", 64'(gid[0]), 64'(exp_ga));
        if (exp_gb >= 0) chk("grant_b", 64'(gid[1]), 64'(exp_gb));
        for (int cyc = 2; cyc <= done; cyc++) begin
            tick();
            m_rd = junk();
        end
        if (!tmo) begin
            m_dok = 1'b1;
            m_rd  = rd;
        end
        tick();
        m_dok = 1'b0;
        m_rd  = junk();
        for (int d = 0; d < 2; d++) begin
            chk("bubble_mvalid", 64'(mv[d]), 64'd0);
            chk("bubble_busy", 64'(bsy[d]), 64'd0);
            vld[d][w[d]] = 1'b0;
        end
    endtask

    task automatic reset_mid_op();
        for (int d = 0; d < 2; d++) push_req(d, model_pick(d, vld[d]));
        tick();
        for (int d = 0; d < 2; d++) chk("midrst_start", 64'(mv[d]), 64'd1);
        tick();
        reset = 1'b0;
        vld[0] = '0;
        vld[1] = '0;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("midrst_mvalid", 64'(mv[d]), 64'd0);
            chk("midrst_busy", 64'(bsy[d]), 64'd0);
            chk("midrst_dok", 64'(dok[d]), 64'd0);
            chk("midrst_maddr", maddr[d], 64'd0);
        end
        tick();
        ptr[0] = 0;
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0] bits;
        for (int d = 0; d < 2; d++) begin
            vld[d] = '0;
            for (int ch = 0; ch < 3; ch++) begin
                ch_addr[d][ch] = '0;
                ch_size[d][ch] = '0;
                ch_strb[d][ch] = '0;
                ch_wdata[d][ch] = '0;
            end
        end
        m_dok = 1'b0;
        m_rd  = '0;
        do_reset();

        // single read from channel 0
        for (int d = 0; d < 2; d++) set_req(d, 0, 64'h8000_0000, 8'h00, 64'd0);
        run_txn(2, 64'hDEAD_BEEF, 0, 0);

        // contention on channels 0 and 1: RR alternates, fixed priority stays on 0
        do_reset();
        for (int t = 0; t < 4; t++) begin
            add_reqs(0, 3'b011);
            add_reqs(1, 3'b011);
            run_txn(3, junk(), t % 2, 0);
        end

        // fixed priority: 110 then 111, channel 2 starved
        do_reset();
        add_reqs(0, 3'b110);
        add_reqs(1, 3'b110);
        run_txn(2, junk(), 1, 1);
        add_reqs(0, 3'b111);
        add_reqs(1, 3'b111);
        run_txn(2, junk(), 2, 0);
        for (int t = 0; t < 3; t++) begin
            add_reqs(0, 3'b011);
            add_reqs(1, 3'b011);
            run_txn(2, junk(), -1, 0);
        end

        // timeout, then data_ok landing on the timeout cycle
        do_reset();
        add_reqs(0, 3'b001);
        add_reqs(1, 3'b001);
        run_txn(9, junk(), 0, 0);
        add_reqs(0, 3'b010);
        add_reqs(1, 3'b010);
        run_txn(8, 64'h0123_4567_89AB_CDEF, 1, 1);

        // reset while busy, then a fresh request
        add_reqs(0, 3'b101);
        add_reqs(1, 3'b101);
        reset_mid_op();
        add_reqs(0, 3'b111);
        add_reqs(1, 3'b111);
        run_txn(2, junk(), 0, 0);

        // write from channel 2, pointer wraps to 0
        do_reset();
        for (int d = 0; d < 2; d++) set_req(d, 2, {$urandom, $urandom}, 8'hFF, 64'h1234);
        run_txn(2, junk(), 2, 2);
        add_reqs(0, 3'b111);
        add_reqs(1, 3'b111);
        run_txn(2, junk(), 0, 0);

        // randomized traffic
        do_reset();
        for (int t = 0; t < 40; t++) begin
            for (int d = 0; d < 2; d++) begin
                bits = 3'($urandom_range(0, 7));
                if ((vld[d] | bits) == 3'b000) bits = 3'(1 << $urandom_range(0, 2));
                add_reqs(d, bits);
            end
            run_txn($urandom_range(1, 9), junk(), -1, -1);
        end

        tick();
        chk("exp_req_drained", 64'(exp_req.size()), 64'd0);
        chk("exp_cpl_drained", 64'(exp_cpl.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Parametrised N-channel memory-bus arbiter. Merges the core's request channels (ibus fetch, dbus load/store, later PTW/DMA) onto one downstream memory port.
- Generalises the current two-port split to NCH channels.
- Adds round-robin or fixed-priority selection, a registered downstream request, and a per-transaction timeout with an error report.
- Sits between the core's request outputs and the memory/cache interconnect.

Parameters:
- NCH, 2, number of upstream channels (≥2); channel 0 = ibus by convention.
- AW, 64, address width.
- DW, 64, data width; strobe width = DW/8.
- MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT, 0, max BUSY cycles before forced completion; 0 = disabled.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk rising edge).
- s_valid  in  NCH  per-channel request valid; held stable until that channel's s_data_ok.
- s_addr  in  NCH*AW  per-channel address.
- s_size  in  NCH*3  per-channel access size code.
- s_strobe  in  NCH*(DW/8)  write strobes; all zero = read.
- s_wdata  in  NCH*DW  write data.
- s_data_ok  out  NCH  one-hot completion pulse to the granted channel.
- s_rdata  out  DW  read data, shared by all channels; valid when s_data_ok[i].
- m_valid  out  1  downstream request valid.
- m_addr, m_size, m_strobe, m_wdata  out  AW/3/(DW/8)/DW  registered downstream request fields.
- m_data_ok  in  1  downstream completion.
- m_rdata  in  DW  downstream read data.
- grant_id  out  $clog2(NCH)  channel currently served.
- busy  out  1  high in BUSY.
- err_timeout  out  1  one-cycle pulse on forced completion.

Behaviour:
- Reset (reset==0):
  - state IDLE; rr_ptr=0; grant_id=0; timeout counter 0.
  - Outputs: m_valid=0, m_* fields=0, s_data_ok=0, busy=0, err_timeout=0.
  - Reset mid-transaction drops it silently: no data_ok pulse, downstream request deasserted.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any s_valid is high, pick a winner.
  - MODE 0: first set bit at or after rr_ptr, wrapping NCH-1→0.
  - MODE 1: lowest set index.
  - Latch the winner's addr/size/strobe/wdata into the m_* registers; grant_id ← winner; go to BUSY.
  - Latency: m_valid is high the cycle after s_valid is sampled.
  - If no s_valid is high, stay in IDLE with m_valid=0.
- BUSY:
  - m_valid=1 and m_* fields held constant.
  - On m_data_ok:
    - Same cycle, combinational: s_data_ok[grant_id]=1, s_rdata=m_rdata.
    - Next state IDLE; m_valid=0 next cycle.
    - MODE 0 only: rr_ptr ← (grant_id+1) mod NCH.
  - Back-to-back requests see a mandatory one-cycle IDLE bubble, so a completed channel's stale valid is never regranted.
- Timeout (TIMEOUT>0):
  - Counter cleared on entry to BUSY, increments each BUSY cycle without m_data_ok.
  - When the counter reaches TIMEOUT-1 without m_data_ok, that cycle: s_data_ok[grant_id]=1, s_rdata=0, err_timeout=1; go to IDLE.
  - m_data_ok in the same cycle as the timeout takes precedence: normal completion, no err_timeout.
  - Counter width: $clog2(TIMEOUT+1); the counter never wraps.
- s_valid dropping while BUSY is ignored. The transaction completes and the data_ok pulse is still emitted.
- s_rdata = m_rdata whenever s_data_ok is nonzero from a normal completion; otherwise 0.
- NCH not a power of two: rr_ptr wraps at NCH, never at 2^width.

Decomposition:
- Package arb_pkg holds:
  - state enum arb_state_t {IDLE, BUSY}.
  - Localparam helpers for channel index width.
  - Packed per-channel request struct arb_req_t {addr, size, strobe, wdata}, reusing the common u64 typedef.
- One sub-module: rr_pick (parameters NCH, MODE). Inputs: request vector, pointer. Outputs: winner index and any_valid. Purely combinational rotate-and-priority-encode.

Test Plan:
- Single read: s_valid=01, s_addr[0]=0x8000_0000.
  - Next cycle: m_valid=1, m_addr=0x8000_0000, grant_id=0.
  - m_data_ok with m_rdata=0xDEAD_BEEF → same-cycle s_data_ok=01, s_rdata=0xDEAD_BEEF; m_valid=0 next cycle.
- Round-robin contention, MODE 0, NCH=2, s_valid=11 held for 4 transactions, each m_data_ok 2 cycles after m_valid:
  - Grants alternate 0,1,0,1.
  - Exactly one IDLE bubble between transactions.
- Fixed priority, MODE 1, NCH=3, s_valid=110 then 111:
  - First grant is 1; after completion grant is 0.
  - Channel 2 is starved while 0 or 1 are valid.
- Timeout, TIMEOUT=8, no m_data_ok:
  - On the 8th BUSY cycle: s_data_ok[grant_id]=1, s_rdata=0, err_timeout=1 for 1 cycle.
  - Next cycle: IDLE.
  - Repeat with m_data_ok on that same cycle → err_timeout=0, rdata passed through.
- Reset mid-op: drive reset=0 while BUSY.
  - Next edge: m_valid=0, busy=0, no s_data_ok.
  - After release, a fresh request is granted from channel 0.
- Write, NCH=3, rr wrap: ch2 request with s_strobe=0xFF, s_wdata=0x1234.
  - m_strobe=0xFF, m_wdata=0x1234.
  - After completion rr_ptr=0: with all three channels requesting, next grant is 0.
